// File: rtl/bus_retime_pkg.sv
// Shared defaults and helpers for the bus retiming pipeline.
package bus_retime_pkg;

  localparam int WIDTH_DEF  = 4;
  localparam int STAGES_DEF = 2;

  // Occupancy ranges over 0 .. 2*stages inclusive.
  function automatic int occ_width(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/bus_retime_stage.sv
// One elastic register slice: a main register plus a one-entry skid buffer,
// with upstream ready taken straight from a flop.
module bus_retime_stage #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [WIDTH-1:0] down_data
);

  logic             m_valid;
  logic             s_valid;
  logic [WIDTH-1:0] m_data;
  logic [WIDTH-1:0] s_data;

  // Ready depends only on the skid flag, so out_ready never ripples upstream.
  assign up_ready   = !s_valid;
  assign down_valid = m_valid;
  assign down_data  = m_data;

  // NOTE: non-blocking assignments make every stage see its neighbours' pre-edge state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      // NOTE: data registers are reset too, so out_data reads 0 out of reset instead of X.
      m_data  <= '0;
      s_data  <= '0;
    end else if (s_valid) begin
      // Full: nothing can be accepted; drain the skid into main when allowed.
      if (down_ready) begin
        m_data  <= s_data;
        s_valid <= 1'b0;
      end
    end else if (up_valid) begin
      if (!m_valid || down_ready) begin
        m_valid <= 1'b1;
        m_data  <= up_data;
      end else begin
        // First backpressure cycle: the skid absorbs the word in flight.
        s_valid <= 1'b1;
        s_data  <= up_data;
      end
    end else if (down_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/bus_retime_pipe.sv
// Elastic bus retiming pipeline: STAGES chained skid slices, optional output
// bit reversal and a running count of words held.
module bus_retime_pipe
  import bus_retime_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int STAGES  = STAGES_DEF,
  parameter int REVERSE = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [occ_width(STAGES)-1:0] occupancy
);

  localparam int CW = occ_width(STAGES);

  // Index g is the interface feeding stage g; index STAGES is the pipe output.
  logic [STAGES:0]  valid_chain;
  logic [STAGES:0]  ready_chain;
  logic [WIDTH-1:0] data_chain [STAGES+1];

  assign valid_chain[0]      = in_valid;
  assign data_chain[0]       = in_data;
  assign in_ready            = ready_chain[0];
  assign ready_chain[STAGES] = out_ready;
  assign out_valid           = valid_chain[STAGES];

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    bus_retime_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .up_valid   (valid_chain[g]),
      .up_ready   (ready_chain[g]),
      .up_data    (data_chain[g]),
      .down_valid (valid_chain[g+1]),
      .down_ready (ready_chain[g+1]),
      .down_data  (data_chain[g+1])
    );
  end

  if (REVERSE != 0) begin : g_reverse
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      assign out_data[b] = data_chain[STAGES][WIDTH-1-b];
    end
  end else begin : g_straight
    assign out_data = data_chain[STAGES];
  end

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy <= '0;
    end else if (in_fire && !out_fire) begin
      occupancy <= occupancy + CW'(1);
    end else if (out_fire && !in_fire) begin
      occupancy <= occupancy - CW'(1);
    end
  end

endmodule
